// File: rtl/io_bank_pkg.sv
// io_bank_pkg: configuration field layout shared by the multi-pad I/O tile.
package io_bank_pkg;
   localparam int CFG_BITS = 3;
   localparam int DIR_BIT = 0;
   localparam int IN_REG_BIT = 1;
   localparam int OUT_REG_BIT = 2;
   function automatic int chain_len(input int n);
      return CFG_BITS * n;
   endfunction
endpackage

// File: rtl/io_bank_pad_cell.sv
// io_bank_pad_cell: one GPIO pad with selectable input synchroniser and output register.
module io_bank_pad_cell
   import io_bank_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   inout  wire                 pad,
   input  logic                outpad,
   input  logic [CFG_BITS-1:0] field,
   input  logic                oe,
   output logic                inpad
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   out_q;
   logic                   drive;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         out_q  <= 1'b0;
      end else begin
         sync_q[0] <= pad;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         out_q <= outpad;
      end
   end
   assign drive = field[OUT_REG_BIT] ? out_q : outpad;
   assign pad   = oe ? drive : 1'bz;
   assign inpad = field[IN_REG_BIT] ? sync_q[SYNC_STAGES-1] : pad;
endmodule

// File: rtl/logical_tile_io_bank.sv
// logical_tile_io_bank: NUM_PADS GPIO pads configured through a serial ccff chain;
// pads stay tri-stated until a full chain length has been shifted in.
module logical_tile_io_bank
   import io_bank_pkg::*;
#(
   parameter int NUM_PADS    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                prog_clk,
   input  logic                pReset,
   inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
   input  logic [NUM_PADS-1:0] io_outpad,
   input  logic                ccff_head,
   input  logic                ccff_en,
   output logic [NUM_PADS-1:0] io_inpad,
   output logic                ccff_tail,
   output logic                cfg_loaded
);
   localparam int L  = chain_len(NUM_PADS);
   localparam int CW = $clog2(L + 1);
   logic [L-1:0]        chain;
   logic [CW-1:0]       shift_cnt;
   logic [NUM_PADS-1:0] oe;
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         chain     <= '0;
         shift_cnt <= '0;
      end else if (ccff_en) begin
         chain <= {chain[L-2:0], ccff_head};
         if (!cfg_loaded) shift_cnt <= shift_cnt + CW'(1);
      end
   end
   assign cfg_loaded = shift_cnt == CW'(L);
   assign ccff_tail  = chain[L-1];
   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      // Never drive while the chain is partial or still moving.
      assign oe[p] = chain[CFG_BITS*p+DIR_BIT] & cfg_loaded & ~ccff_en;
      io_bank_pad_cell #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_cell (
         .clk   (prog_clk),
         .rst   (pReset),
         .pad   (gfpga_pad_GPIO_PAD[p]),
         .outpad(io_outpad[p]),
         .field (chain[CFG_BITS*p +: CFG_BITS]),
         .oe    (oe[p]),
         .inpad (io_inpad[p])
      );
   end
endmodule

// File: tb/tb_logical_tile_io_bank.sv
// tb_logical_tile_io_bank: directed checks of the 4-pad I/O tile with 2-stage synchronisers.
module tb_logical_tile_io_bank;
   localparam int N = 4;
   logic         prog_clk = 1'b0;
   logic         pReset = 1'b0;
   logic         ccff_head = 1'b0;
   logic         ccff_en = 1'b0;
   logic [N-1:0] io_outpad = '0;
   logic [N-1:0] ext_en = '0;
   logic [N-1:0] ext_val = '0;
   wire  [N-1:0] pad;
   logic [N-1:0] io_inpad;
   logic         ccff_tail;
   logic         cfg_loaded;
   int           errors = 0;
   int           checks = 0;

   always #5 prog_clk = ~prog_clk;

   for (genvar g = 0; g < N; g++) begin : g_ext
      assign pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
   end

   logical_tile_io_bank #(.NUM_PADS(N), .SYNC_STAGES(2)) dut (
      .prog_clk          (prog_clk),
      .pReset            (pReset),
      .gfpga_pad_GPIO_PAD(pad),
      .io_outpad         (io_outpad),
      .ccff_head         (ccff_head),
      .ccff_en           (ccff_en),
      .io_inpad          (io_inpad),
      .ccff_tail         (ccff_tail),
      .cfg_loaded        (cfg_loaded)
   );

   task automatic do_reset();
      ccff_en = 1'b0;
      pReset  = 1'b1;
      @(negedge prog_clk);
      pReset = 1'b0;
   endtask

   task automatic shift_bit(input logic b);
      ccff_en   = 1'b1;
      ccff_head = b;
      @(negedge prog_clk);
   endtask

   task automatic load_word(input logic [11:0] w);
      for (int i = 11; i >= 0; i--) shift_bit(w[i]);
      ccff_en = 1'b0;
   endtask

   // A pad is proven undriven by holding it low externally while the fabric offers 1.
   task automatic test_reset();
      @(negedge prog_clk);
      do_reset();
      io_outpad = 4'hF;
      ext_en    = 4'hF;
      ext_val   = 4'b0100;
      #1;
      checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL reset_cfg_loaded: got %b want 0", cfg_loaded); end
      checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b want 0", ccff_tail); end
      checks++; if (io_inpad !== 4'b0100) begin errors++; $display("FAIL reset_pad2_in: got %b want 0100", io_inpad); end
      ext_val = 4'b0000;
      #1;
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL reset_pads_z: got %b want 0000", io_inpad); end
      ext_en = '0;
   endtask

   task automatic test_out_reg();
      do_reset();
      io_outpad = '0;
      ext_en    = 4'b1110;
      ext_val   = '0;
      for (int i = 11; i >= 0; i--) begin
         shift_bit(12'h005 >> i);
         if (i == 1) begin
            checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL load_after11: got %b want 0", cfg_loaded); end
         end
      end
      checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL load_after12: got %b want 1", cfg_loaded); end
      ccff_en   = 1'b0;
      io_outpad = 4'hF;
      #1;
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL outreg_before: got %b want 0000", io_inpad); end
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0001) begin errors++; $display("FAIL outreg_rise: got %b want 0001", io_inpad); end
      io_outpad = 4'h0;
      #1;
      checks++; if (io_inpad !== 4'b0001) begin errors++; $display("FAIL outreg_hold: got %b want 0001", io_inpad); end
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL outreg_fall: got %b want 0000", io_inpad); end
      ext_en = '0;
   endtask

   task automatic test_sync();
      do_reset();
      ext_en  = 4'hF;
      ext_val = '0;
      load_word(12'h010);
      repeat (3) @(negedge prog_clk);
      ext_val = 4'b0110;
      #1;
      checks++; if (io_inpad !== 4'b0100) begin errors++; $display("FAIL sync_t0: got %b want 0100", io_inpad); end
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0100) begin errors++; $display("FAIL sync_t1: got %b want 0100", io_inpad); end
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0110) begin errors++; $display("FAIL sync_t2: got %b want 0110", io_inpad); end
      ext_val = 4'b0000;
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0010) begin errors++; $display("FAIL sync_fall_t1: got %b want 0010", io_inpad); end
      @(negedge prog_clk);
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL sync_fall_t2: got %b want 0000", io_inpad); end
      ext_en = '0;
   endtask

   task automatic test_back_to_back();
      logic [11:0] a;
      logic [11:0] b;
      a = 12'hA65;
      b = 12'h34C;
      do_reset();
      io_outpad = 4'hF;
      ext_en    = 4'hF;
      ext_val   = '0;
      for (int i = 11; i >= 0; i--) begin
         shift_bit(a[i]);
         checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL b2b_z_first%0d: got %b want 0000", i, io_inpad); end
      end
      for (int k = 0; k < 12; k++) begin
         checks++; if (ccff_tail !== a[11-k]) begin errors++; $display("FAIL b2b_tail%0d: got %b want %b", k, ccff_tail, a[11-k]); end
         shift_bit(b[11-k]);
         checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL b2b_z_second%0d: got %b want 0000", k, io_inpad); end
         checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL b2b_loaded%0d: got %b want 1", k, cfg_loaded); end
      end
      checks++; if (ccff_tail !== b[11]) begin errors++; $display("FAIL b2b_tail_end: got %b want %b", ccff_tail, b[11]); end
      ext_en  = '0;
      ccff_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      io_outpad = 4'hF;
      ext_en    = 4'hF;
      ext_val   = '0;
      repeat (7) shift_bit(1'b1);
      ccff_en = 1'b0;
      do_reset();
      checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL mid_cfg_loaded: got %b want 0", cfg_loaded); end
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL mid_pads_z: got %b want 0000", io_inpad); end
      ext_en = 4'b1110;
      for (int i = 11; i >= 0; i--) begin
         shift_bit(12'h001 >> i);
         if (i == 1) begin
            checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL mid_after11: got %b want 0", cfg_loaded); end
         end
      end
      checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL mid_after12: got %b want 1", cfg_loaded); end
      ccff_en   = 1'b0;
      io_outpad = 4'h1;
      #1;
      checks++; if (io_inpad !== 4'b0001) begin errors++; $display("FAIL comb_out_hi: got %b want 0001", io_inpad); end
      io_outpad = 4'hE;
      #1;
      checks++; if (io_inpad !== 4'b0000) begin errors++; $display("FAIL comb_out_lo: got %b want 0000", io_inpad); end
      ext_en = '0;
   endtask

   task automatic test_reset_vs_en();
      pReset    = 1'b1;
      ccff_en   = 1'b1;
      ccff_head = 1'b1;
      repeat (12) @(negedge prog_clk);
      pReset  = 1'b0;
      ccff_en = 1'b0;
      checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL rst_en_tail: got %b want 0", ccff_tail); end
      checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL rst_en_loaded: got %b want 0", cfg_loaded); end
      for (int i = 0; i < 11; i++) begin
         shift_bit(1'b0);
         checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL rst_en_chain%0d: got %b want 0", i, ccff_tail); end
      end
      ccff_en = 1'b0;
      checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL rst_en_cnt: got %b want 0", cfg_loaded); end
   endtask

   initial begin
      test_reset();
      test_out_reg();
      test_sync();
      test_back_to_back();
      test_reset_mid();
      test_reset_vs_en();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/logical_tile_io_bank.md
# logical_tile_io_bank

Parametrised multi-pad I/O tile: NUM_PADS bidirectional GPIO pads, each configured by a 3-bit field loaded serially through the configuration-chain (ccff) shift register. Each pad has a selectable input synchroniser and a selectable output register. Outputs stay tri-stated until a complete configuration has been shifted in. The block sits at the fabric boundary, as a drop-in generalisation of the single-pad io logical tile, and is chained into the fabric ccff path.

## Interface
Parameters:
- NUM_PADS, 4, number of pads; range 1..32
- SYNC_STAGES, 2, input synchroniser depth; range 1..3

Ports:
- prog_clk  input  1  single clock for the chain, counter and pad registers
- pReset  input  1  reset; one clock; reset is synchronous and active-high
- gfpga_pad_GPIO_PAD  inout  NUM_PADS  external pads
- io_outpad  input  NUM_PADS  fabric data to drive onto the pads
- ccff_head  input  1  serial configuration in
- ccff_en  input  1  shift enable for the configuration chain
- io_inpad  output  NUM_PADS  pad data returned to the fabric
- ccff_tail  output  1  serial configuration out, to the next tile
- cfg_loaded  output  1  high once a full chain length has been shifted in

## Operation
- Chain length L = 3*NUM_PADS. Register chain[L-1:0]; field of pad p is chain[3p+2:3p].
- Field bits per pad:
  - bit0 dir: 1 = drive the pad
  - bit1 in_reg: 1 = synchronised input path
  - bit2 out_reg: 1 = registered output path
- Shift: when ccff_en=1, chain <= {chain[L-2:0], ccff_head}. ccff_tail = chain[L-1] (registered). When ccff_en=0, the chain holds.
- Bit order: the first bit shifted in ends at chain[L-1], which is pad NUM_PADS-1 bit2. The last bit shifted in ends at chain[0], which is pad 0 dir.
- Load counter shift_cnt, width clog2(L+1):
  - increments on each ccff_en cycle and saturates at L
  - cfg_loaded = (shift_cnt == L)
  - further shifts after saturation keep shifting; cfg_loaded stays 1
- Output enable: oe[p] = dir[p] & cfg_loaded & ~ccff_en. When oe[p]=0 the pad is driven Z.
- Output data:
  - out_reg=1: pad = out_q[p], where out_q <= io_outpad every cycle
  - out_reg=0: pad = io_outpad[p] combinationally
- Input data: io_inpad[p] always reflects the pad, including loopback when driving.
  - in_reg=1: output of a SYNC_STAGES-deep flop chain
  - in_reg=0: raw pad value, combinational
- A field change takes effect on the cycle after the shift that writes it. No glitch-free guarantee while ccff_en=1; the pads are tri-stated during that time in any case.

## Timing
- Reset values (pReset=1 at a clock edge):
  - chain = 0, shift_cnt = 0, cfg_loaded = 0, ccff_tail = 0
  - out_q = 0, all synchroniser flops = 0
  - all pads Z
  - io_inpad follows the pad, because every field is 0 and therefore in_reg=0
- Reset mid-shift: the partial configuration is discarded and cfg_loaded drops on the next cycle. A full L-bit reload is required.
- ccff_head to ccff_tail latency: L cycles of ccff_en=1.
- cfg_loaded rises in the same cycle that chain[0] receives the L-th bit, so oe can assert on the first cycle after ccff_en falls.
- Input path latency: SYNC_STAGES cycles when in_reg=1; 0 when in_reg=0.
- Output path latency: 1 cycle when out_reg=1; 0 when out_reg=0.
- ccff_en=1 and pReset=1 in the same cycle: reset wins.

## Structure
- Package io_bank_pkg holds:
  - CFG_BITS = 3
  - DIR_BIT = 0, IN_REG_BIT = 1, OUT_REG_BIT = 2
  - function chain_len(n) = CFG_BITS*n
- Sub-module io_bank_pad_cell, instantiated per pad. It holds the synchroniser (parameter SYNC_STAGES), out_q, the path muxes and the tri-state driver. Inputs to the cell are the 3-bit field and oe.
- The top level holds the chain, shift_cnt, cfg_loaded and the oe gating.

## Test plan
- Reset, then pad 2 driven 1 externally, with no shift -> cfg_loaded=0, all pads Z, io_inpad[2]=1 combinationally.
- NUM_PADS=4: shift in 12 bits with pad0 field = dir=1, out_reg=1, then deassert ccff_en, then io_outpad[0]=1 -> pad0 reads 1 one cycle later; other pads Z; cfg_loaded=1 after the 12th shift.
- Pad1 field in_reg=1, SYNC_STAGES=2, external pad toggled 0 to 1 -> io_inpad[1] rises exactly 2 cycles later.
- Shift 12 bits, then shift 12 more with ccff_en held -> ccff_tail reproduces the first 12 bits in order; all pads Z for the whole 24 cycles; cfg_loaded stays 1.
- pReset asserted after 7 of 12 shifts -> cfg_loaded=0 and pads Z; 12 further shifts are needed before cfg_loaded=1.
- pReset and ccff_en high together -> chain stays 0 and ccff_tail=0.
